// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and saturation limits for the adder accumulator
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int MAX_W = 64;

    // Callers truncate the result to their own WIDTH.
    function automatic logic [MAX_W-1:0] max_pos(input int width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] max_neg(input int width);
        return MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/bypass_adder.sv
// rtl/bypass_adder.sv - WIDTH-bit adder with carry-in, carry-out and signed overflow flag
module bypass_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum      = full[WIDTH-1:0];
        cout     = full[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - signed beat accumulator with optional saturation and result handshake
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SAT_EN = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(max_neg(WIDTH));

    acc_state_t       state, state_nx;
    logic [WIDTH-1:0] acc_q, acc_nx;
    logic             ovf_q, ovf_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             rdy_en;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] add_res;
    logic             accept;

    bypass_adder #(.WIDTH(WIDTH)) u_adder (
        .a        (acc_q),
        .b        (in_data),
        .cin      (1'b0),
        .sum      (sum),
        .cout     (cout),
        .overflow (ovf)
    );

    // On signed overflow a carry-out means both operands were negative.
    always_comb begin
        add_res = sum;
        if (ovf && SAT_EN)
            add_res = cout ? MAX_NEG : MAX_POS;
    end

    // rdy_en keeps in_ready low during reset and until the first edge after it.
    assign in_ready   = rdy_en && (state != HOLD);
    assign accept     = in_valid && in_ready;
    assign acc_valid  = (state == HOLD);
    assign acc_out    = acc_q;
    assign ovf_sticky = ovf_q;
    assign count      = cnt_q;

    always_comb begin
        state_nx = state;
        acc_nx   = acc_q;
        ovf_nx   = ovf_q;
        cnt_nx   = cnt_q;
        if (clear) begin
            state_nx = IDLE;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_nx   = add_res;
                        ovf_nx   = ovf_q | ovf;
                        cnt_nx   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                        state_nx = in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                        acc_nx   = '0;
                        ovf_nx   = 1'b0;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    acc_nx   = '0;
                    ovf_nx   = 1'b0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nx;
            acc_q  <= acc_nx;
            ovf_q  <= ovf_nx;
            cnt_q  <= cnt_nx;
            rdy_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - directed self-checking bench for adder_accumulator
module tb_adder_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        s_in_ready, s_acc_valid, s_ovf;
    logic [31:0] s_acc;
    logic [7:0]  s_cnt;
    logic        w_in_ready, w_acc_valid, w_ovf;
    logic [31:0] w_acc;
    logic [7:0]  w_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_accumulator #(.WIDTH(32), .SAT_EN(1'b1), .CNT_W(8)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .acc_valid  (s_acc_valid),
        .out_ready  (out_ready),
        .acc_out    (s_acc),
        .ovf_sticky (s_ovf),
        .count      (s_cnt)
    );

    adder_accumulator #(.WIDTH(32), .SAT_EN(1'b0), .CNT_W(8)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (w_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .acc_valid  (w_acc_valid),
        .out_ready  (out_ready),
        .acc_out    (w_acc),
        .ovf_sticky (w_ovf),
        .count      (w_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        #2;
        chk("rst_in_ready", {31'd0, s_in_ready}, 32'd0);
        chk("rst_acc_valid", {31'd0, s_acc_valid}, 32'd0);
        chk("rst_acc_out", s_acc, 32'd0);
        chk("rst_count", {24'd0, s_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, s_ovf}, 32'd0);
        tick();
        chk("rst_held_in_ready", {31'd0, s_in_ready}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, s_in_ready}, 32'd1);

        // 52 - 31 + 2539 = 2560
        out_ready = 1'b1;
        send(32'd52, 1'b0);
        chk("t1_running_acc", s_acc, 32'd52);
        chk("t1_accum_valid", {31'd0, s_acc_valid}, 32'd0);
        send(-32'sd31, 1'b0);
        send(32'd2539, 1'b1);
        chk("t1_acc_valid", {31'd0, s_acc_valid}, 32'd1);
        chk("t1_acc_out", s_acc, 32'd2560);
        chk("t1_count", {24'd0, s_cnt}, 32'd3);
        chk("t1_ovf", {31'd0, s_ovf}, 32'd0);
        chk("t1_in_ready_hold", {31'd0, s_in_ready}, 32'd0);
        tick();
        chk("t1_handoff_valid", {31'd0, s_acc_valid}, 32'd0);
        chk("t1_handoff_acc", s_acc, 32'd0);
        chk("t1_handoff_count", {24'd0, s_cnt}, 32'd0);
        chk("t1_handoff_ready", {31'd0, s_in_ready}, 32'd1);

        // saturating: max+1 -> max, then -1 -> max-1; wrapping: min, then -1 -> max
        out_ready = 1'b0;
        send(32'h7fff_ffff, 1'b0);
        send(32'd1, 1'b0);
        chk("t2_sat_clip", s_acc, 32'h7fff_ffff);
        chk("t2_sat_ovf_early", {31'd0, s_ovf}, 32'd1);
        chk("t2_wrap_min", w_acc, 32'h8000_0000);
        send(32'hffff_ffff, 1'b1);
        chk("t2_sat_acc", s_acc, 32'd2147483646);
        chk("t2_sat_ovf", {31'd0, s_ovf}, 32'd1);
        chk("t2_sat_count", {24'd0, s_cnt}, 32'd3);
        chk("t2_wrap_acc", w_acc, 32'h7fff_ffff);
        chk("t2_wrap_ovf", {31'd0, w_ovf}, 32'd1);
        out_ready = 1'b1;
        tick();

        // -2^31 + -1
        send(32'h8000_0000, 1'b0);
        chk("t3_no_ovf_yet", {31'd0, w_ovf}, 32'd0);
        send(32'hffff_ffff, 1'b1);
        chk("t3_wrap_acc", w_acc, 32'h7fff_ffff);
        chk("t3_wrap_ovf", {31'd0, w_ovf}, 32'd1);
        chk("t3_sat_acc", s_acc, 32'h8000_0000);
        chk("t3_sat_ovf", {31'd0, s_ovf}, 32'd1);
        chk("t3_wrap_valid", {31'd0, w_acc_valid}, 32'd1);
        tick();

        // HOLD with back-pressure for 5 cycles
        out_ready = 1'b0;
        send(32'd4000, 1'b0);
        send(32'd47, 1'b1);
        chk("t4_hold_acc", s_acc, 32'd4047);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd100;
            tick();
            chk($sformatf("t4_hold_ready_%0d", i), {31'd0, s_in_ready}, 32'd0);
            chk($sformatf("t4_hold_acc_%0d", i), s_acc, 32'd4047);
            chk($sformatf("t4_hold_cnt_%0d", i), {24'd0, s_cnt}, 32'd2);
            chk($sformatf("t4_hold_valid_%0d", i), {31'd0, s_acc_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_release_valid", {31'd0, s_acc_valid}, 32'd0);
        chk("t4_release_acc", s_acc, 32'd0);
        chk("t4_release_ready", {31'd0, s_in_ready}, 32'd1);

        // clear mid-group with a beat present
        out_ready = 1'b0;
        send(32'd10, 1'b0);
        clear = 1'b1;
        send(32'd4561, 1'b0);
        clear = 1'b0;
        chk("t5_clear_acc", s_acc, 32'd0);
        chk("t5_clear_count", {24'd0, s_cnt}, 32'd0);
        chk("t5_clear_valid", {31'd0, s_acc_valid}, 32'd0);
        chk("t5_clear_ready", {31'd0, s_in_ready}, 32'd1);
        send(32'd5, 1'b1);
        chk("t5_hold_before_clear", {31'd0, s_acc_valid}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_hold_discarded", {31'd0, s_acc_valid}, 32'd0);
        chk("t5_hold_acc_zero", s_acc, 32'd0);

        // asynchronous reset between edges during ACCUM
        send(32'd7, 1'b0);
        send(32'd8, 1'b0);
        chk("t6_pre_rst_acc", s_acc, 32'd15);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_acc", s_acc, 32'd0);
        chk("t6_async_count", {24'd0, s_cnt}, 32'd0);
        chk("t6_async_ready", {31'd0, s_in_ready}, 32'd0);
        chk("t6_async_valid", {31'd0, s_acc_valid}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("t6_ready_after_rst", {31'd0, s_in_ready}, 32'd1);
        send(32'd0, 1'b0);
        send(32'd0, 1'b1);
        chk("t6_acc", s_acc, 32'd0);
        chk("t6_count", {24'd0, s_cnt}, 32'd2);
        chk("t6_valid", {31'd0, s_acc_valid}, 32'd1);
        out_ready = 1'b1;
        tick();

        // beat counter saturates at 255
        out_ready = 1'b0;
        for (int i = 0; i < 259; i++) send(32'd1, 1'b0);
        chk("t7_cnt_sat_accum", {24'd0, s_cnt}, 32'd255);
        chk("t7_acc_sum", s_acc, 32'd259);
        send(32'd1, 1'b1);
        chk("t7_cnt_sat_hold", {24'd0, s_cnt}, 32'd255);
        chk("t7_acc_final", s_acc, 32'd260);
        out_ready = 1'b1;
        tick();
        chk("t7_cnt_zero", {24'd0, s_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and accumulator width in bits.
REQ-002 SHALL have parameter SAT_EN, default 1, meaning 1 = saturate on signed overflow and 0 = two's-complement wrap.
REQ-003 SHALL have parameter CNT_W, default 8, meaning beat-counter width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port clear, input, 1 bit, synchronous abort and zero of the current accumulation.
REQ-007 SHALL have port in_valid, input, 1 bit, operand beat present.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts a beat.
REQ-009 SHALL have port in_data, input, WIDTH bits, signed operand.
REQ-010 SHALL have port in_last, input, 1 bit, final beat of the group.
REQ-011 SHALL have port acc_valid, output, 1 bit, result presented.
REQ-012 SHALL have port out_ready, input, 1 bit, downstream takes the result.
REQ-013 SHALL have port acc_out, output, WIDTH bits, signed accumulated result.
REQ-014 SHALL have port ovf_sticky, output, 1 bit, at least one overflow occurred in the group.
REQ-015 SHALL have port count, output, CNT_W bits, beats accepted in the group.

Function
REQ-016 SHALL implement states IDLE, ACCUM and HOLD.
- IDLE: accumulator 0; first accepted beat moves to ACCUM.
- In_last on that beat moves directly to HOLD.
REQ-017 SHALL define a beat as accepted when in_valid and in_ready are both 1 at a clock edge.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-018 SHALL, on each accepted beat, compute acc + in_data with cin = 0 and register the result at that same edge.
- Single-cycle throughput; one beat per clock.
REQ-019 SHALL detect signed overflow when both operand signs are equal and differ from the sum sign.
- SAT_EN = 1: store 2^(WIDTH-1)-1 for positive overflow, -2^(WIDTH-1) for negative overflow.
- SAT_EN = 0: store the wrapped sum.
- Either mode: set ovf_sticky.
REQ-020 SHALL treat a saturated accumulator as an ordinary value for later beats.
- Example: max + (-1) = max-1; ovf_sticky stays 1.
REQ-021 SHALL increment count per accepted beat and saturate at 2^CNT_W-1 without wrapping.
REQ-022 SHALL enter HOLD on the edge that accepts an in_last beat.
- acc_valid = 1 from the next cycle.
- acc_out, ovf_sticky and count held stable while acc_valid=1 and out_ready=0.
- Latency from last beat to acc_valid: 1 cycle.
REQ-023 SHALL, when acc_valid and out_ready are both 1 at an edge, return to IDLE.
- Zero the accumulator, ovf_sticky and count.
- in_ready = 1 in the following cycle; no beat is accepted in the handoff cycle.
REQ-024 SHALL give clear priority over all other events in any state.
- Next state IDLE with all registers zeroed.
- A beat presented with clear is dropped and not counted.
- A HOLD result present with clear is discarded.
REQ-025 SHALL keep acc_out = current running accumulator in IDLE and ACCUM; acc_out is only qualified by acc_valid.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously force:
- state IDLE
- acc_out = 0, ovf_sticky = 0, count = 0
- acc_valid = 0, in_ready = 0
REQ-027 SHALL assert in_ready = 1 on the first clock edge after rst_n deasserts.
- A reset mid-group loses the partial sum with no output produced.

Structure
REQ-028 SHALL place the state encoding (IDLE/ACCUM/HOLD) and the saturation constants MAX_POS/MAX_NEG as functions of WIDTH in a shared package adder_pkg.
REQ-029 SHALL instantiate the team's existing bypass_adder as its only sub-module.
- Ports a, b, cin, sum, cout and overflow.
- Its overflow output drives REQ-019.
- No separate adder in this block.

Verification
REQ-030 SHALL cover: beats 52, -31, 2539(last) with out_ready=1 -> acc_valid one cycle after last, acc_out=2560, count=3, ovf_sticky=0.
REQ-031 SHALL cover: SAT_EN=1, beats 2147483647, 1, -1(last) -> acc_out=2147483646, ovf_sticky=1, count=3.
REQ-032 SHALL cover: SAT_EN=0, beats -2147483648, -1(last) -> acc_out=2147483647, ovf_sticky=1.
REQ-033 SHALL cover: result 4047 in HOLD, out_ready=0 for 5 cycles.
- in_ready=0; beats on in_valid ignored; acc_out stable.
- out_ready=1 -> IDLE next cycle, acc_out=0.
REQ-034 SHALL cover: clear asserted with a beat of 4561 mid-group -> next cycle IDLE, acc_out=0, count=0, acc_valid=0.
REQ-035 SHALL cover: rst_n pulsed low asynchronously between edges during ACCUM -> outputs zero immediately; a new group 0, 0(last) yields acc_out=0, count=2.
